mac_dot_seq: RTL and testbench

//  Job sequencer for the 16x16->40-bit multi-cycle MAC unit (mac_top).

---
 rtl/mac_dot_seq.sv | 163 ++++++++++++++++
 tb/tb_mac_dot_seq.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mac_dot_seq.sv
// rtl/mac_dot_seq.sv - job sequencer feeding signed operand pairs to a multi-cycle MAC
//
// Consumes a stream of signed 16-bit operand pairs ending with a last flag.
// Clears the MAC accumulator at job start and issues one MAC start per pair.
// Returns the 40-bit dot product on a valid/ready result port.
//
// Ports
//   clk, rst_n                      clock (rising edge), async active-low reset
//   in_valid/in_ready/in_m/in_q/in_last   operand pair stream
//   out_valid/out_ready/out_result/out_count/err_len/err_to   job result
//   busy                            sequencer not idle
//   mac_start/mac_m/mac_q/mac_clr   commands to the MAC unit
//   mac_product/mac_ready           MAC accumulator value and completion pulse
module mac_dot_seq #(
  parameter int MAX_LEN = 256,
  parameter int CNT_W   = 9,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [15:0]        in_m,
  input  logic [15:0]        in_q,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [39:0]        out_result,
  output logic [CNT_W-1:0]   out_count,
  output logic               err_len,
  output logic               err_to,
  output logic               busy,
  output logic               mac_start,
  output logic [15:0]        mac_m,
  output logic [15:0]        mac_q,
  output logic               mac_clr,
  input  logic [39:0]        mac_product,
  input  logic               mac_ready
);

  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  // count+1 == MAX_LEN is tested as count == MAX_LEN-1 so the counter never has to hold MAX_LEN+1
  localparam logic [CNT_W-1:0] LEN_LAST = CNT_W'(MAX_LEN - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_count;
  logic [TMR_W-1:0]  r_timer;
  logic [15:0]       r_mac_m;
  logic [15:0]       r_mac_q;
  logic              r_last;
  logic              r_mac_start;
  logic [39:0]       r_result;
  logic              r_err_len;
  logic              r_err_to;
  logic              w_accept;
  logic              w_len_hit;
  logic              w_tmr_hit;

  assign w_accept  = (r_state == S_ISSUE) && in_valid;
  assign w_len_hit = (r_count == LEN_LAST);
  assign w_tmr_hit = (r_timer == TMR_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next = S_CLR;
      S_CLR:   w_next = S_ISSUE;
      S_ISSUE: if (in_valid) w_next = S_WAIT;
      S_WAIT: begin
        // A completion in the same cycle as the timeout wins over the timeout
        if (mac_ready) begin
          if (r_last || w_len_hit) w_next = S_DONE;
          else                     w_next = S_ISSUE;
        end else if (w_tmr_hit) begin
          w_next = S_DONE;
        end
      end
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count     <= '0;
      r_timer     <= '0;
      r_mac_m     <= '0;
      r_mac_q     <= '0;
      r_last      <= 1'b0;
      r_mac_start <= 1'b0;
      r_result    <= '0;
      r_err_len   <= 1'b0;
      r_err_to    <= 1'b0;
    end else begin
      r_mac_start <= 1'b0;
      case (r_state)
        S_CLR: begin
          r_count   <= '0;
          r_result  <= '0;
          r_err_len <= 1'b0;
          r_err_to  <= 1'b0;
        end
        S_ISSUE: begin
          if (w_accept) begin
            r_mac_m     <= in_m;
            r_mac_q     <= in_q;
            r_last      <= in_last;
            r_mac_start <= 1'b1;
            r_timer     <= '0;
          end
        end
        S_WAIT: begin
          r_timer <= r_timer + 1'b1;
          if (mac_ready) begin
            r_count  <= r_count + 1'b1;
            r_result <= mac_product;
            if (!r_last && w_len_hit) r_err_len <= 1'b1;
          end else if (w_tmr_hit) begin
            r_err_to <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_err_len <= 1'b0;
            r_err_to  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = (r_state == S_ISSUE);
  assign mac_clr    = (r_state == S_CLR);
  assign out_valid  = (r_state == S_DONE);
  assign busy       = (r_state != S_IDLE);
  assign mac_start  = r_mac_start;
  assign mac_m      = r_mac_m;
  assign mac_q      = r_mac_q;
  assign out_result = r_result;
  assign out_count  = r_count;
  assign err_len    = r_err_len;
  assign err_to     = r_err_to;

endmodule

// File: tb/tb_mac_dot_seq.sv
// tb/tb_mac_dot_seq.sv - directed self-checking bench for mac_dot_seq with a behavioural MAC
module tb_mac_dot_seq;

  localparam int CNT_W = 3;
  localparam int LAT   = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid, in_ready, in_last;
  logic [15:0]       in_m, in_q;
  logic              out_valid, out_ready;
  logic [39:0]       out_result;
  logic [CNT_W-1:0]  out_count;
  logic              err_len, err_to, busy;
  logic              mac_start, mac_clr, mac_ready;
  logic [15:0]       mac_m, mac_q;
  logic [39:0]       mac_product;

  mac_dot_seq #(.MAX_LEN(4), .CNT_W(CNT_W), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_m(in_m), .in_q(in_q), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_count(out_count), .err_len(err_len), .err_to(err_to), .busy(busy),
    .mac_start(mac_start), .mac_m(mac_m), .mac_q(mac_q), .mac_clr(mac_clr),
    .mac_product(mac_product), .mac_ready(mac_ready)
  );

  always #5 clk = ~clk;

  // Behavioural MAC: completes LAT+1 cycles after it sees mac_start
  logic               mac_en;
  logic signed [39:0] acc;
  int                 lat_cnt;
  logic signed [31:0] prod;
  assign prod        = $signed(mac_m) * $signed(mac_q);
  assign mac_product = acc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      lat_cnt   <= 0;
      mac_ready <= 1'b0;
    end else begin
      mac_ready <= 1'b0;
      if (mac_clr) acc <= '0;
      if (mac_start) begin
        lat_cnt <= LAT;
      end else if (lat_cnt != 0) begin
        lat_cnt <= lat_cnt - 1;
        if (lat_cnt == 1 && mac_en) begin
          mac_ready <= 1'b1;
          acc       <= acc + {{8{prod[31]}}, prod};
        end
      end
    end
  end

  int clr_cnt = 0, start_cnt = 0, acc_cnt = 0;
  always @(posedge clk) begin
    if (mac_clr)              clr_cnt++;
    if (mac_start)            start_cnt++;
    if (in_valid && in_ready) acc_cnt++;
  end

  int n_pass = 0, n_total = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push(input logic [15:0] m, input logic [15:0] q, input logic last);
    int n = 0;
    in_m = m; in_q = q; in_last = last; in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("push_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result();
    int n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("wait_valid", out_valid, 1);
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("after_take_valid", out_valid, 0);
    check("after_take_errs", {err_len, err_to}, 0);
  endtask

  int c0, s0, a0;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_m = '0; in_q = '0; in_last = 1'b0;
    out_ready = 1'b0; mac_en = 1'b1;
    #12;
    check("rst_outs", {out_valid, in_ready, busy, mac_start, mac_clr, err_len, err_to}, 0);
    check("rst_result", out_result, 0);
    check("rst_count", out_count, 0);
    check("rst_mac_m", mac_m, 0);
    @(negedge clk); rst_n = 1'b1;

    // T1: 10*10 + 5*2 + 2*(-3) = 104
    c0 = clr_cnt; s0 = start_cnt;
    push(16'd10, 16'd10, 1'b0);
    check("t1_clr_before_start", clr_cnt - c0, 1);
    check("t1_no_start_yet", start_cnt - s0, 0);
    push(16'd5, 16'd2, 1'b0);
    push(16'd2, -16'sd3, 1'b1);
    wait_result();
    check("t1_result", out_result, 104);
    check("t1_count", out_count, 3);
    check("t1_errs", {err_len, err_to}, 0);
    check("t1_clr_once", clr_cnt - c0, 1);
    check("t1_starts", start_cnt - s0, 3);
    take_result();

    // T2 + T3: fresh accumulator, result held while out_ready low
    push(16'd4, 16'd4, 1'b1);
    wait_result();
    check("t2_result", out_result, 16);
    check("t2_count", out_count, 1);
    s0 = start_cnt;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("t3_hold_valid", out_valid, 1);
      check("t3_hold_result", out_result, 16);
      check("t3_in_ready", in_ready, 0);
    end
    check("t3_no_start", start_cnt - s0, 0);
    take_result();

    // T4: MAX_LEN=4 truncation, 5th pair left pending then starts next job
    a0 = acc_cnt;
    for (int i = 0; i < 4; i++) push(16'd1, 16'd1, 1'b0);
    in_m = 16'd1; in_q = 16'd1; in_last = 1'b0; in_valid = 1'b1;
    wait_result();
    check("t4_result", out_result, 4);
    check("t4_count", out_count, 4);
    check("t4_err_len", err_len, 1);
    check("t4_err_to", err_to, 0);
    check("t4_accepted", acc_cnt - a0, 4);
    take_result();
    push(16'd1, 16'd1, 1'b0);
    push(16'd2, 16'd3, 1'b1);
    wait_result();
    check("t4b_result", out_result, 7);
    check("t4b_count", out_count, 2);
    check("t4b_err_len", err_len, 0);
    take_result();

    // T5: MAC never answers, TIMEOUT=8
    mac_en = 1'b0;
    push(16'd3, 16'd3, 1'b1);
    check("t5_start", mac_start, 1);
    repeat (7) @(posedge clk);
    #1;
    check("t5_not_yet", out_valid, 0);
    @(posedge clk); #1;
    check("t5_valid", out_valid, 1);
    check("t5_err_to", err_to, 1);
    check("t5_err_len", err_len, 0);
    check("t5_count", out_count, 0);
    check("t5_result", out_result, 0);
    mac_en = 1'b1;
    take_result();

    // T6: reset during WAIT abandons the job
    push(16'd1, 16'd2, 1'b0);
    push(16'd3, 16'd4, 1'b0);
    check("t6_pre_result", out_result, 2);
    check("t6_pre_start", mac_start, 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_outs", {out_valid, in_ready, busy, mac_start, mac_clr, err_len, err_to}, 0);
    check("t6_rst_result", out_result, 0);
    check("t6_rst_count", out_count, 0);
    check("t6_rst_mac_m", {mac_m, mac_q}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("t6_busy_after", busy, 0);
    check("t6_no_valid_after", out_valid, 0);
    push(16'h8000, 16'h8000, 1'b1);
    wait_result();
    check("t6_result", out_result, 40'd1073741824);
    check("t6_count", out_count, 1);
    take_result();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
